// File: rtl/sram_array_ctrl_if.sv
// Request/response bus between a requester and the SRAM array sequencer.
interface sram_array_ctrl_if #(
  parameter int unsigned AW   = 2,
  parameter int unsigned COLS = 8
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            resp_valid;
  logic [COLS-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/sram_array_ctrl.sv
// Sequencer for a ROWS x COLS mixed-signal SRAM array: wordline pulses, writer
// data and sense-amp sampling for single-word requests, with optional write-verify.
module sram_array_ctrl #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned WL_CYC    = 1,
  parameter int unsigned VERIFY    = 0,
  parameter int unsigned AW        = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  sram_array_ctrl_if.slave    bus,
  output logic [ROWS-1:0]     row_wr,
  output logic [ROWS-1:0]     row_rd,
  output logic [COLS-1:0]     data_in,
  input  logic [COLS-1:0]     sa_data
);

  localparam int unsigned MAXC = (SETUP_CYC > WL_CYC) ? SETUP_CYC : WL_CYC;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WSETUP, S_WPULSE, S_RECOV1, S_RPULSE, S_RECOV2, S_RESP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [COLS-1:0] r_wdata;
  logic [COLS-1:0] r_rdata;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [COLS-1:0] r_resp_rdata;
  logic            r_resp_err;
  logic [ROWS-1:0] r_row_wr;
  logic [ROWS-1:0] r_row_rd;
  logic [COLS-1:0] r_data_in;

  logic            w_accept;
  logic            w_oor;
  logic [ROWS-1:0] w_req_line;
  logic [ROWS-1:0] w_lat_line;

  assign w_accept   = bus.req_valid && r_req_ready;
  assign w_oor      = 32'(bus.req_addr) >= ROWS;
  // The read path fires its wordline on the accept edge, before r_addr is loaded.
  assign w_req_line = ROWS'(1) << bus.req_addr;
  assign w_lat_line = ROWS'(1) << r_addr;

  // Phase counters hold (cycles - 1) and count down to zero in each timed state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_row_wr     <= '0;
      r_row_rd     <= '0;
      r_data_in    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_we        <= bus.req_we;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            if (w_oor) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_err   <= 1'b1;
            end else if (bus.req_we) begin
              r_state   <= S_WSETUP;
              r_cnt     <= CW'(SETUP_CYC - 1);
              r_data_in <= bus.req_wdata;
            end else begin
              r_state  <= S_RPULSE;
              r_cnt    <= CW'(WL_CYC - 1);
              r_row_rd <= w_req_line;
            end
          end
        end
        S_WSETUP: begin
          if (r_cnt == '0) begin
            r_state  <= S_WPULSE;
            r_cnt    <= CW'(WL_CYC - 1);
            r_row_wr <= w_lat_line;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_WPULSE: begin
          if (r_cnt == '0) begin
            r_state  <= S_RECOV1;
            r_row_wr <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RECOV1: begin
          if (VERIFY != 0) begin
            r_state  <= S_RPULSE;
            r_cnt    <= CW'(WL_CYC - 1);
            r_row_rd <= w_lat_line;
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
          end
        end
        S_RPULSE: begin
          if (r_cnt == '0) begin
            r_state  <= S_RECOV2;
            r_row_rd <= '0;
            r_rdata  <= sa_data;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RECOV2: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_rdata;
          r_resp_err   <= r_we && (r_rdata != r_wdata);
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_row_wr     <= '0;
          r_row_rd     <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign row_wr         = r_row_wr;
  assign row_rd         = r_row_rd;
  assign data_in        = r_data_in;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: three configurations, an SRAM cell model and a
// response scoreboard with latency tracking.
module tb_sram_array_ctrl;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
    logic [7:0] lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // a: defaults; b: ROWS=3 with write-verify; c: stretched SETUP_CYC=2, WL_CYC=3
  sram_array_ctrl_if #(.AW(2), .COLS(8)) bus_a ();
  sram_array_ctrl_if #(.AW(2), .COLS(8)) bus_b ();
  sram_array_ctrl_if #(.AW(2), .COLS(8)) bus_c ();

  logic [3:0] row_wr_a, row_rd_a, row_wr_c, row_rd_c;
  logic [2:0] row_wr_b, row_rd_b;
  logic [3:0] wr_b4, rd_b4;
  logic [7:0] data_in_a, data_in_b, data_in_c;
  logic [7:0] sa_a, sa_b, sa_c;

  assign wr_b4 = {1'b0, row_wr_b};
  assign rd_b4 = {1'b0, row_rd_b};

  sram_array_ctrl #(.ROWS(4), .COLS(8), .SETUP_CYC(1), .WL_CYC(1), .VERIFY(0)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .row_wr(row_wr_a), .row_rd(row_rd_a), .data_in(data_in_a), .sa_data(sa_a)
  );
  sram_array_ctrl #(.ROWS(3), .COLS(8), .SETUP_CYC(1), .WL_CYC(1), .VERIFY(1)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .row_wr(row_wr_b), .row_rd(row_rd_b), .data_in(data_in_b), .sa_data(sa_b)
  );
  sram_array_ctrl #(.ROWS(4), .COLS(8), .SETUP_CYC(2), .WL_CYC(3), .VERIFY(0)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c),
    .row_wr(row_wr_c), .row_rd(row_rd_c), .data_in(data_in_c), .sa_data(sa_c)
  );

  // Cell model: a write wordline stores data_in, a read wordline returns the row.
  logic [7:0] mem [3][4];
  logic [2:0] ov_en;
  logic [7:0] ov_val [3];

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (rst) begin
        mem[0][r] <= 8'h00;
        mem[1][r] <= 8'h00;
        mem[2][r] <= 8'h00;
      end else begin
        if (row_wr_a[r]) mem[0][r] <= data_in_a;
        if (wr_b4[r])    mem[1][r] <= data_in_b;
        if (row_wr_c[r]) mem[2][r] <= data_in_c;
      end
    end
  end

  always_comb begin
    sa_a = ov_en[0] ? ov_val[0] : 8'h00;
    sa_b = ov_en[1] ? ov_val[1] : 8'h00;
    sa_c = ov_en[2] ? ov_val[2] : 8'h00;
    for (int r = 0; r < 4; r++) begin
      if (!ov_en[0] && row_rd_a[r]) sa_a = mem[0][r];
      if (!ov_en[1] && rd_b4[r])    sa_b = mem[1][r];
      if (!ov_en[2] && row_rd_c[r]) sa_c = mem[2][r];
    end
  end

  exp_t       q0[$], q1[$], q2[$];
  logic [7:0] sh [3][4];
  int         lat_cnt [3];
  logic [3:0] prv_wr [3];
  logic [3:0] prv_rd [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] f_wr(input int d);
    case (d)
      0:       return row_wr_a;
      1:       return wr_b4;
      default: return row_wr_c;
    endcase
  endfunction

  function automatic logic [3:0] f_rd(input int d);
    case (d)
      0:       return row_rd_a;
      1:       return rd_b4;
      default: return row_rd_c;
    endcase
  endfunction

  function automatic logic [7:0] f_din(input int d);
    case (d)
      0:       return data_in_a;
      1:       return data_in_b;
      default: return data_in_c;
    endcase
  endfunction

  function automatic logic f_ready(input int d);
    case (d)
      0:       return bus_a.req_ready;
      1:       return bus_b.req_ready;
      default: return bus_c.req_ready;
    endcase
  endfunction

  function automatic logic f_vld(input int d);
    case (d)
      0:       return bus_a.req_valid;
      1:       return bus_b.req_valid;
      default: return bus_c.req_valid;
    endcase
  endfunction

  function automatic logic f_rv(input int d);
    case (d)
      0:       return bus_a.resp_valid;
      1:       return bus_b.resp_valid;
      default: return bus_c.resp_valid;
    endcase
  endfunction

  function automatic logic [7:0] f_rdata(input int d);
    case (d)
      0:       return bus_a.resp_rdata;
      1:       return bus_b.resp_rdata;
      default: return bus_c.resp_rdata;
    endcase
  endfunction

  function automatic logic f_err(input int d);
    case (d)
      0:       return bus_a.resp_err;
      1:       return bus_b.resp_err;
      default: return bus_c.resp_err;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int d, output exp_t e);
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic drive(input int d, input logic v, input logic we, input logic [1:0] a,
                       input logic [7:0] wd);
    case (d)
      0: begin bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = a; bus_a.req_wdata = wd; end
      1: begin bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = a; bus_b.req_wdata = wd; end
      default: begin
        bus_c.req_valid = v; bus_c.req_we = we; bus_c.req_addr = a; bus_c.req_wdata = wd;
      end
    endcase
  endtask

  // Accept-to-response latency of each configuration.
  function automatic logic [7:0] lat_of(input int d, input logic we);
    case (d)
      0:       return we ? 8'd4 : 8'd3;
      1:       return we ? 8'd6 : 8'd3;
      default: return we ? 8'd7 : 8'd5;
    endcase
  endfunction

  function automatic bit wl_ok(input logic [3:0] wr, input logic [3:0] rd,
                               input logic [3:0] pw, input logic [3:0] pr);
    return ($countones(wr) <= 1) && ($countones(rd) <= 1) && !(wr != 0 && rd != 0) &&
           !(wr != 0 && pr != 0) && !(rd != 0 && pw != 0);
  endfunction

  // Issue one request at a negedge; returns at the negedge of cycle 1 after accept.
  task automatic do_op(input int d, input logic we, input logic [1:0] a, input logic [7:0] wd,
                       input bit hold, input bit want_resp, input bit ovr,
                       input logic [7:0] x_rd, input logic x_err);
    exp_t e;
    bit   oor;
    for (int i = 0; i < 64 && f_ready(d) !== 1'b1; i++) @(negedge clk);
    check($sformatf("d%0d_ready_at_issue", d), 32'(f_ready(d)), 32'd1);
    oor   = (d == 1) && (a == 2'd3);
    e.lat = oor ? 8'd1 : lat_of(d, we);
    if (oor) begin
      e.rdata = 8'h00; e.err = 1'b1;
    end else if (ovr) begin
      e.rdata = x_rd; e.err = x_err;
    end else if (we) begin
      e.rdata = (d == 1) ? wd : 8'h00; e.err = 1'b0;
    end else begin
      e.rdata = sh[d][a]; e.err = 1'b0;
    end
    if (want_resp) push(d, e);
    if (we && !oor) sh[d][a] = wd;
    drive(d, 1'b1, we, a, wd);
    @(negedge clk);
    if (!hold) drive(d, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  // Cycle index since the last accept (cycle 1 is the first cycle after accept).
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst)                                         lat_cnt[d] = 0;
      else if (f_vld(d) === 1'b1 && f_ready(d) === 1'b1) lat_cnt[d] = 1;
      else                                             lat_cnt[d] = lat_cnt[d] + 1;
    end
  end

  // Response scoreboard and wordline rules, sampled mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic [3:0] wr;
      logic [3:0] rd;
      exp_t       e;
      wr = f_wr(d);
      rd = f_rd(d);
      check($sformatf("d%0d_wordline_rules", d), 32'(wl_ok(wr, rd, prv_wr[d], prv_rd[d])), 32'd1);
      prv_wr[d] = wr;
      prv_rd[d] = rd;
      if (f_rv(d) === 1'b1) begin
        check($sformatf("d%0d_resp_expected", d), 32'(qsize(d) != 0), 32'd1);
        if (qsize(d) != 0) begin
          pop(d, e);
          check($sformatf("d%0d_resp_rdata", d), 32'(f_rdata(d)), 32'(e.rdata));
          check($sformatf("d%0d_resp_err", d), 32'(f_err(d)), 32'(e.err));
          check($sformatf("d%0d_resp_latency", d), 32'(lat_cnt[d]), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    exp_t e2;
    rst   = 1'b1;
    ov_en = 3'b000;
    for (int d = 0; d < 3; d++) begin
      ov_val[d] = 8'h00;
      prv_wr[d] = 4'h0;
      prv_rd[d] = 4'h0;
      lat_cnt[d] = 0;
      for (int r = 0; r < 4; r++) sh[d][r] = 8'h00;
      drive(d, 1'b0, 1'b0, 2'd0, 8'h00);
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d_rst_ready", d), 32'(f_ready(d)), 32'd1);
      check($sformatf("d%0d_rst_resp_valid", d), 32'(f_rv(d)), 32'd0);
      check($sformatf("d%0d_rst_rdata", d), 32'(f_rdata(d)), 32'd0);
      check($sformatf("d%0d_rst_err", d), 32'(f_err(d)), 32'd0);
      check($sformatf("d%0d_rst_row_wr", d), 32'(f_wr(d)), 32'd0);
      check($sformatf("d%0d_rst_row_rd", d), 32'(f_rd(d)), 32'd0);
      check($sformatf("d%0d_rst_data_in", d), 32'(f_din(d)), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Write addr 2 = 0xA5 then read it back (defaults).
    do_op(0, 1'b1, 2'd2, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("a_wr_data_in_c1", 32'(data_in_a), 32'hA5);
    check("a_wr_ready_c1", 32'(bus_a.req_ready), 32'd0);
    check("a_wr_row_wr_c1", 32'(row_wr_a), 32'h0);
    @(negedge clk);
    check("a_wr_row_wr_c2", 32'(row_wr_a), 32'h4);
    @(negedge clk);
    check("a_wr_row_wr_c3", 32'(row_wr_a), 32'h0);
    @(negedge clk);
    check("a_wr_resp_c4", 32'(bus_a.resp_valid), 32'd1);
    @(negedge clk);
    check("a_wr_ready_c5", 32'(bus_a.req_ready), 32'd1);
    do_op(0, 1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("a_rd_row_rd_c1", 32'(row_rd_a), 32'h4);
    @(negedge clk);
    check("a_rd_row_rd_c2", 32'(row_rd_a), 32'h0);
    @(negedge clk);
    check("a_rd_resp_c3", 32'(bus_a.resp_valid), 32'd1);

    // Verified write with a mismatching sense-amp word.
    ov_en[1]  = 1'b1;
    ov_val[1] = 8'h3D;
    do_op(1, 1'b1, 2'd1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3D, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("b_vfy_row_wr_c%0d", c), 32'(wr_b4), (c == 2) ? 32'h2 : 32'h0);
      check($sformatf("b_vfy_row_rd_c%0d", c), 32'(rd_b4), (c == 4) ? 32'h2 : 32'h0);
      if (c < 6) @(negedge clk);
    end
    check("b_vfy_resp_c6", 32'(bus_b.resp_valid), 32'd1);
    @(negedge clk);
    ov_en[1] = 1'b0;
    do_op(1, 1'b1, 2'd2, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Out-of-range read and write on the 3-row array.
    do_op(1, 1'b0, 2'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("b_oor_rd_resp_c1", 32'(bus_b.resp_valid), 32'd1);
    check("b_oor_rd_row_rd_c1", 32'(rd_b4), 32'h0);
    check("b_oor_rd_row_wr_c1", 32'(wr_b4), 32'h0);
    check("b_oor_rd_data_in_c1", 32'(data_in_b), 32'h5A);
    @(negedge clk);
    check("b_oor_rd_ready_c2", 32'(bus_b.req_ready), 32'd1);
    do_op(1, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check("b_oor_wr_data_in_c1", 32'(data_in_b), 32'h5A);
    check("b_oor_wr_row_wr_c1", 32'(wr_b4), 32'h0);

    // Stretched timing: write addr 3 then read with a word that changes per cycle.
    do_op(2, 1'b1, 2'd3, 8'h77, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("c_wr_row_wr_c%0d", c), 32'(row_wr_c), (c >= 3 && c <= 5) ? 32'h8 : 32'h0);
      @(negedge clk);
    end
    check("c_wr_resp_c7", 32'(bus_c.resp_valid), 32'd1);
    do_op(2, 1'b0, 2'd3, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
    ov_en[2] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      ov_val[2] = (c == 1) ? 8'h11 : (c == 2) ? 8'h22 : 8'h33;
      check($sformatf("c_rd_row_rd_c%0d", c), 32'(row_rd_c), (c <= 3) ? 32'h8 : 32'h0);
      @(negedge clk);
    end
    check("c_rd_resp_c5", 32'(bus_c.resp_valid), 32'd1);
    ov_en[2] = 1'b0;

    // Reset during the second read-pulse cycle: pulse cut, no response.
    do_op(2, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("c_rst_row_rd_c1", 32'(row_rd_c), 32'h1);
    @(negedge clk);
    check("c_rst_row_rd_c2", 32'(row_rd_c), 32'h1);
    rst = 1'b1;
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 4; r++) sh[d][r] = 8'h00;
    @(negedge clk);
    check("c_rst_row_rd_cut", 32'(row_rd_c), 32'h0);
    check("c_rst_ready", 32'(bus_c.req_ready), 32'd1);
    check("c_rst_no_resp", 32'(bus_c.resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("c_rst_ready_next", 32'(bus_c.req_ready), 32'd1);
    check("c_rst_no_resp_next", 32'(bus_c.resp_valid), 32'd0);
    do_op(2, 1'b0, 2'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Handshake: req_valid held with a changing address while busy.
    do_op(0, 1'b1, 2'd0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    do_op(0, 1'b1, 2'd1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    do_op(0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    check("hs_ready_c1", 32'(bus_a.req_ready), 32'd0);
    check("hs_row_rd_c1", 32'(row_rd_a), 32'h1);
    drive(0, 1'b1, 1'b0, 2'd1, 8'h00);
    @(negedge clk);
    check("hs_ready_c2", 32'(bus_a.req_ready), 32'd0);
    check("hs_row_rd_c2", 32'(row_rd_a), 32'h0);
    drive(0, 1'b1, 1'b0, 2'd2, 8'h00);
    @(negedge clk);
    check("hs_ready_c3", 32'(bus_a.req_ready), 32'd0);
    drive(0, 1'b1, 1'b0, 2'd1, 8'h00);
    @(negedge clk);
    check("hs_ready_c4", 32'(bus_a.req_ready), 32'd1);
    e2.rdata = 8'h22;
    e2.err   = 1'b0;
    e2.lat   = 8'd3;
    push(0, e2);
    @(negedge clk);
    check("hs_second_row_rd", 32'(row_rd_a), 32'h2);
    check("hs_second_ready", 32'(bus_a.req_ready), 32'd0);
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);

    // Mixed random traffic across all three configurations.
    for (int k = 0; k < 30; k++) begin
      int         d;
      logic       we;
      logic [1:0] a;
      logic [7:0] wd;
      d  = k % 3;
      we = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      wd = 8'($urandom);
      do_op(d, we, a, wd, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    end

    repeat (16) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d_all_responses_seen", d), 32'(qsize(d)), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
